// File: rtl/smm_pkg.sv
// smm_pkg: shared widths, issue-FSM states and element placement for the Strassen operand loader.
package smm_pkg;
  localparam int DATAWIDTH = 32;
  localparam int BLOCKSIZE = DATAWIDTH * 4;
  localparam int BUSWIDTH = BLOCKSIZE * 4;
  typedef enum logic [1:0] {IDLE, LOAD, GAP} issue_state_e;
  // {row hi, col hi} picks the 2x2 block, {row lo, col lo} the element inside it
  function automatic int unsigned blk_offset(input logic [3:0] beat, input int unsigned dw = DATAWIDTH);
    return 32'({beat[3], beat[1], beat[2], beat[0]}) * dw;
  endfunction
endpackage

// File: rtl/smm_tile_bank.sv
// smm_tile_bank: one fill bank holding a blocked A/B matrix pair, its mode bit and a full flag.
module smm_tile_bank #(
  parameter int DATAWIDTH = smm_pkg::DATAWIDTH,
  parameter int BUSWIDTH = smm_pkg::BUSWIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_i,
  input  logic [3:0]           beat_i,
  input  logic [DATAWIDTH-1:0] a_i,
  input  logic [DATAWIDTH-1:0] b_i,
  input  logic                 sel_i,
  input  logic                 clr_i,
  output logic [BUSWIDTH-1:0]  a_o,
  output logic [BUSWIDTH-1:0]  b_o,
  output logic                 sel_o,
  output logic                 full_o
);
  import smm_pkg::*;
  logic [BUSWIDTH-1:0] a_q, b_q;
  logic sel_q, full_q;
  assign a_o = a_q;
  assign b_o = b_q;
  assign sel_o = sel_q;
  assign full_o = full_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      sel_q <= 1'b0;
      full_q <= 1'b0;
    end else begin
      if (wr_i) begin
        a_q[blk_offset(beat_i, DATAWIDTH) +: DATAWIDTH] <= a_i;
        b_q[blk_offset(beat_i, DATAWIDTH) +: DATAWIDTH] <= b_i;
        if (beat_i == 4'd0) sel_q <= sel_i;
      end
      full_q <= (full_q && !clr_i) || (wr_i && &beat_i);
    end
  end
endmodule

// File: rtl/smm_operand_loader.sv
// smm_operand_loader: reorders a row-major A/B element stream into quadrant-blocked buses
// and issues them to the Strassen multiplier through two ping-pong fill banks.
module smm_operand_loader #(
  parameter int DATAWIDTH = smm_pkg::DATAWIDTH,
  parameter int BLOCKSIZE = DATAWIDTH * 4,
  parameter int BUSWIDTH = BLOCKSIZE * 4,
  parameter int LOAD_CYCLES = 3,
  parameter int GAP_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATAWIDTH-1:0] s_a,
  input  logic [DATAWIDTH-1:0] s_b,
  input  logic                 s_sel,
  output logic [BUSWIDTH-1:0]  A,
  output logic [BUSWIDTH-1:0]  B,
  output logic                 load,
  output logic                 sel,
  output logic                 busy
);
  import smm_pkg::*;
  localparam int CW = $clog2((LOAD_CYCLES > GAP_CYCLES ? LOAD_CYCLES : GAP_CYCLES) + 1);
  issue_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] beat_q;
  logic fill_ptr_q, issue_ptr_q, issue, accept, load_done, gap_done;
  logic [1:0] full, wr, clr, bank_sel;
  logic [BUSWIDTH-1:0] bank_a [2];
  logic [BUSWIDTH-1:0] bank_b [2];
  logic [BUSWIDTH-1:0] a_q, b_q;
  logic sel_q;
  assign s_ready = !rst && !full[fill_ptr_q];
  assign accept = s_valid && s_ready;
  assign wr = {accept && fill_ptr_q, accept && !fill_ptr_q};
  assign clr = {issue && issue_ptr_q, issue && !issue_ptr_q};
  for (genvar i = 0; i < 2; i++) begin : g_bank
    smm_tile_bank #(.DATAWIDTH(DATAWIDTH), .BUSWIDTH(BUSWIDTH)) u_bank (
      .clk(clk),
      .rst(rst),
      .wr_i(wr[i]),
      .beat_i(beat_q),
      .a_i(s_a),
      .b_i(s_b),
      .sel_i(s_sel),
      .clr_i(clr[i]),
      .a_o(bank_a[i]),
      .b_o(bank_b[i]),
      .sel_o(bank_sel[i]),
      .full_o(full[i])
    );
  end
  assign load_done = cnt_q == CW'(LOAD_CYCLES - 1);
  assign gap_done = cnt_q == CW'(GAP_CYCLES - 1);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    issue = 1'b0;
    case (state_q)
      IDLE: begin
        issue = full[issue_ptr_q];
        state_d = issue ? LOAD : IDLE;
        cnt_d = '0;
      end
      LOAD: if (load_done) begin
        state_d = GAP;
        cnt_d = '0;
      end
      GAP: if (gap_done) begin
        state_d = IDLE;
        cnt_d = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      beat_q <= '0;
      fill_ptr_q <= 1'b0;
      issue_ptr_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      sel_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      if (accept) begin
        beat_q <= beat_q + 1'b1;
        if (&beat_q) fill_ptr_q <= !fill_ptr_q;
      end
      if (issue) begin
        a_q <= bank_a[issue_ptr_q];
        b_q <= bank_b[issue_ptr_q];
        sel_q <= bank_sel[issue_ptr_q];
        issue_ptr_q <= !issue_ptr_q;
      end
    end
  end
  assign A = a_q;
  assign B = b_q;
  assign sel = sel_q;
  assign load = state_q == LOAD;
  assign busy = state_q != IDLE || |full;
endmodule
